// File: rtl/vector_bram_writer_pkg.sv
// Shared definitions for the vector BRAM writer: BRAM geometry, FSM states
// and the rule that places the status word directly after the vector.
package vector_bram_writer_pkg;

    localparam int BRAM_DW    = 32;
    localparam int BRAM_DEPTH = 2048;
    localparam int BRAM_AW    = 11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_e;

    // The status word (generation counter) lives at word address VLEN.
    function automatic logic [BRAM_AW-1:0] status_addr(input int vlen);
        return BRAM_AW'(vlen);
    endfunction

endpackage

// File: rtl/vector_bram_writer_if.sv
// PS-side BRAM port A bundle. The PS is the master; the writer block only
// passes these signals through to the BRAM and returns read data.
interface vector_bram_writer_if;

    logic [12:0] bram_porta_0_addr;   // byte address
    logic [31:0] bram_porta_0_din;
    logic [31:0] bram_porta_0_dout;
    logic        bram_porta_0_en;
    logic        bram_porta_0_we;

    modport master (
        output bram_porta_0_addr, bram_porta_0_din, bram_porta_0_en, bram_porta_0_we,
        input  bram_porta_0_dout
    );

    modport slave (
        input  bram_porta_0_addr, bram_porta_0_din, bram_porta_0_en, bram_porta_0_we,
        output bram_porta_0_dout
    );

endinterface

// File: rtl/blk_mem_gen_0.sv
// Behavioural stand-in for the 2048x32 block RAM core. Port A is read/write
// with one cycle of read latency (read-first); port B is configured write-only.
// Both ports run from the common clock, so one process models the array; a
// port B write lands after a port A write to the same word in that cycle.
module blk_mem_gen_0 (
    input  logic        clka,
    input  logic        ena,
    input  logic [0:0]  wea,
    input  logic [10:0] addra,
    input  logic [31:0] dina,
    output logic [31:0] douta,
    input  logic        clkb,
    input  logic        enb,
    input  logic [0:0]  web,
    input  logic [10:0] addrb,
    input  logic [31:0] dinb
);

    logic [31:0] mem [0:2047];

    // clkb is the same net as clka in this common-clock configuration.
    logic unused_clkb;
    assign unused_clkb = clkb;

    // Array update and port A registered read.
    always_ff @(posedge clka) begin
        if (ena) begin
            douta <= mem[addra];
            if (wea[0]) mem[addra] <= dina;
        end
        if (enb && web[0]) mem[addrb] <= dinb;
    end

endmodule

// File: rtl/vector_word_mux.sv
// Snapshot register for the source vector plus an index-selected word output.
// With VECTOR_BRAM_CHANGE_TRIGGER_EN defined it also reports whether the live
// vector differs from the last captured snapshot.
module vector_word_mux
    import vector_bram_writer_pkg::*;
#(
    parameter int VLEN = 1
) (
    input  logic                    clk,
    input  logic                    load_i,
    input  logic [BRAM_DW*VLEN-1:0] vec_i,
    input  logic [BRAM_AW-1:0]      idx_i,
    output logic [BRAM_DW-1:0]      word_o
`ifdef VECTOR_BRAM_CHANGE_TRIGGER_EN
    ,
    output logic                    changed_o
`endif
);

    // Contents are don't-care after reset, so no reset on the snapshot.
    logic [BRAM_DW*VLEN-1:0] snap_q;

    // Capture the whole vector at the start of a pass.
    always_ff @(posedge clk) begin
        if (load_i) snap_q <= vec_i;
    end

    // Select the word at the current index; indices past the vector read 0.
    always_comb begin
        word_o = '0;
        for (int i = 0; i < VLEN; i++) begin
            if (idx_i == BRAM_AW'(i)) word_o = snap_q[BRAM_DW*i +: BRAM_DW];
        end
    end

`ifdef VECTOR_BRAM_CHANGE_TRIGGER_EN
    assign changed_o = (vec_i != snap_q);
`endif

endmodule

// File: rtl/vector_bram_writer.sv
// Copies a VLEN-word vector into BRAM through port B, then writes the
// incremented pass counter as a status word at address VLEN. PS port A is a
// straight pass-through to the same BRAM; collisions are left to the BRAM.
// Optional: VECTOR_BRAM_CHANGE_TRIGGER_EN makes a vector change (or the first
// idle cycle after reset) start a pass as if start had been pulsed.
module vector_bram_writer
    import vector_bram_writer_pkg::*;
#(
    parameter int VLEN = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BRAM_DW*VLEN-1:0] vec,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             gen,
    vector_bram_writer_if.slave     porta
);

    localparam logic [BRAM_AW-1:0] STATUS_ADDR = status_addr(VLEN);

    state_e               state_q, state_d;
    logic [BRAM_AW-1:0]   idx_q, idx_d;
    logic                 pending_q, pending_d;
    logic                 done_q, done_d;
    logic [31:0]          gen_q, gen_d;
    logic                 load;
    logic                 trig;
    logic [BRAM_DW-1:0]   word;

    logic                 enb;
    logic [0:0]           web;
    logic [BRAM_AW-1:0]   addrb;
    logic [BRAM_DW-1:0]   dinb;

    vector_word_mux #(.VLEN(VLEN)) u_mux (
        .clk       (clk),
        .load_i    (load),
        .vec_i     (vec),
        .idx_i     (idx_q),
        .word_o    (word)
`ifdef VECTOR_BRAM_CHANGE_TRIGGER_EN
        ,
        .changed_o (changed)
`endif
    );

`ifdef VECTOR_BRAM_CHANGE_TRIGGER_EN
    logic changed;
    logic first_q;

    // First idle cycle after reset always launches a pass.
    always_ff @(posedge clk) begin
        if (rst)       first_q <= 1'b1;
        else if (load) first_q <= 1'b0;
    end

    assign trig = start | first_q | changed;
`else
    assign trig = start;
`endif

    // State register; reset aborts any pass without touching BRAM contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= 1'b0;
            done_q    <= 1'b0;
            gen_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            done_q    <= done_d;
            gen_q     <= gen_d;
        end
    end

    // Next-state: done and gen move together on the edge entering DONE, and a
    // request seen while busy relaunches straight from DONE.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        pending_d = pending_q;
        done_d    = 1'b0;
        gen_d     = gen_q;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig) begin
                    state_d   = WRITE;
                    idx_d     = '0;
                    load      = 1'b1;
                    pending_d = 1'b0;
                end
            end
            WRITE: begin
                if (start) pending_d = 1'b1;
                if (idx_q == STATUS_ADDR) begin
                    state_d = DONE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                    gen_d   = gen_q + 32'd1;
                end else begin
                    idx_d = idx_q + BRAM_AW'(1);
                end
            end
            DONE: begin
                if (pending_q || start) begin
                    state_d   = WRITE;
                    idx_d     = '0;
                    load      = 1'b1;
                    pending_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Port B: write-only, active for every WRITE cycle; the last one carries
    // the status word, which is the generation value this pass will publish.
    always_comb begin
        enb   = (state_q == WRITE);
        web   = enb;
        addrb = idx_q;
        dinb  = (idx_q == STATUS_ADDR) ? (gen_q + 32'd1) : word;
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign gen  = gen_q;

    // Byte address low bits are not part of the word address.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^porta.bram_porta_0_addr[1:0];

    blk_mem_gen_0 u_bram (
        .clka  (clk),
        .ena   (porta.bram_porta_0_en),
        .wea   (porta.bram_porta_0_we),
        .addra (porta.bram_porta_0_addr[12:2]),
        .dina  (porta.bram_porta_0_din),
        .douta (porta.bram_porta_0_dout),
        .clkb  (clk),
        .enb   (enb),
        .web   (web),
        .addrb (addrb),
        .dinb  (dinb)
    );

endmodule

// File: tb/tb_vector_bram_writer.sv
// Randomized bench for vector_bram_writer (default build, VLEN=4). A simple
// memory/generation model tracks what each completed pass must leave in BRAM;
// contents are read back through PS port A.
module tb_vector_bram_writer;

    localparam int VLEN = 4;
    localparam int VW   = 32 * VLEN;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [VW-1:0] vec;
    logic          busy;
    logic          done;
    logic [31:0]   gen;

    vector_bram_writer_if pa ();

    vector_bram_writer #(.VLEN(VLEN)) dut (
        .clk   (clk),
        .rst   (rst),
        .vec   (vec),
        .start (start),
        .busy  (busy),
        .done  (done),
        .gen   (gen),
        .porta (pa)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    logic [31:0] mmem [0:15];
    logic [31:0] mgen;

    always @(negedge clk) if (done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One completed pass: vector words at 0..VLEN-1, new generation at VLEN.
    task automatic model_pass(input logic [VW-1:0] v);
        for (int i = 0; i < VLEN; i++) mmem[i] = v[32*i +: 32];
        mgen = mgen + 32'd1;
        mmem[VLEN] = mgen;
    endtask

    task automatic pa_wr(input int a, input logic [31:0] d);
        @(negedge clk);
        pa.bram_porta_0_addr = 13'(a * 4);
        pa.bram_porta_0_din  = d;
        pa.bram_porta_0_en   = 1'b1;
        pa.bram_porta_0_we   = 1'b1;
        @(negedge clk);
        pa.bram_porta_0_en   = 1'b0;
        pa.bram_porta_0_we   = 1'b0;
    endtask

    task automatic pa_rd(input int a, output logic [31:0] d);
        @(negedge clk);
        pa.bram_porta_0_addr = 13'(a * 4);
        pa.bram_porta_0_en   = 1'b1;
        pa.bram_porta_0_we   = 1'b0;
        @(negedge clk);
        d = pa.bram_porta_0_dout;
        pa.bram_porta_0_en   = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        logic [31:0] d;
        for (int a = 0; a <= VLEN; a++) begin
            pa_rd(a, d);
            chk($sformatf("%s_mem%0d", tag, a), d, mmem[a]);
        end
    endtask

    // Pulse start once; optionally change vec at cycle tamper_at of the pass.
    task automatic run_pass(input logic [VW-1:0] v, input int tamper_at,
                            input logic [VW-1:0] tv, input string tag);
        int cyc;
        @(negedge clk);
        vec   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 40) begin
            if (cyc == tamper_at) vec = tv;
            @(negedge clk);
            cyc++;
        end
        model_pass(v);
        chk({tag, "_lat"}, 32'(cyc), 32'(VLEN + 2));
        chk({tag, "_gen"}, gen, mgen);
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(done), 32'd0);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        check_mem(tag);
    endtask

    initial begin
        logic [31:0]   d;
        logic [VW-1:0] v1, v2;
        int            d0;

        rst   = 1'b1;
        start = 1'b0;
        vec   = '0;
        pa.bram_porta_0_addr = '0;
        pa.bram_porta_0_din  = '0;
        pa.bram_porta_0_en   = 1'b0;
        pa.bram_porta_0_we   = 1'b0;
        mgen  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_gen", gen, 32'd0);

        // Known BRAM background through port A.
        for (int a = 0; a < 16; a++) begin
            d = $urandom;
            pa_wr(a, d);
            mmem[a] = d;
        end
        check_mem("pre");

        run_pass({32'd4, 32'd3, 32'd2, 32'd1}, 0, '0, "basic");

        for (int k = 0; k < 6; k++)
            run_pass({$urandom, $urandom, $urandom, $urandom}, 0, '0, $sformatf("rnd%0d", k));

        // Vector changes mid-pass must not reach BRAM.
        run_pass({$urandom, $urandom, $urandom, $urandom}, 1, {VLEN{32'hAAAAAAAA}}, "torn1");
        run_pass({$urandom, $urandom, $urandom, $urandom}, 3, {VLEN{32'h55555555}}, "torn3");

        // Three starts while busy collapse into one extra pass.
        v1 = {$urandom, $urandom, $urandom, $urandom};
        v2 = {$urandom, $urandom, $urandom, $urandom};
        d0 = done_cnt;
        @(negedge clk); vec = v1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); vec = v2; start = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (30) @(negedge clk);
        model_pass(v1);
        model_pass(v2);
        chk("pend_dones", 32'(done_cnt - d0), 32'd2);
        chk("pend_gen", gen, mgen);
        chk("pend_idle", 32'(busy), 32'd0);
        check_mem("pend");

        // Reset during WRITE: words 0..1 land, the rest untouched, gen cleared.
        v1 = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk); vec = v1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_gen", gen, 32'd0);
        d0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("abort_nodone", 32'(done_cnt - d0), 32'd0);
        mmem[0] = v1[31:0];
        mmem[1] = v1[63:32];
        mgen    = '0;
        check_mem("abort");

        // Generation counter wrap.
        @(negedge clk);
        force dut.gen_q = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.gen_q;
        mgen = 32'hFFFFFFFF;
        chk("force_gen", gen, 32'hFFFFFFFF);
        run_pass({$urandom, $urandom, $urandom, $urandom}, 0, '0, "wrap");
        chk("wrap_status", mmem[VLEN], 32'd0);

        // A stable vector with no start must not start a pass.
        d0 = done_cnt;
        vec = {$urandom, $urandom, $urandom, $urandom};
        repeat (20) @(negedge clk);
        chk("idle_nodone", 32'(done_cnt - d0), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
